// File: rtl/stage_sequencer_pkg.sv
// Shared architecture definitions for the stage sequencer: stage/instruction-type macros,
// the matching enum, and instruction-class helpers.
`ifndef STAGE_SEQUENCER_ARCH_DEFINES
`define STAGE_SEQUENCER_ARCH_DEFINES
`define STAGE_WIDTH     [2:0]
`define STAGE_FETCH     3'd0
`define STAGE_DECODE    3'd1
`define STAGE_EXECUTE   3'd2
`define STAGE_MEMORY    3'd3
`define STAGE_WRITEBACK 3'd4
`define STAGE_HALTED    3'd5
`define INSTR_LOAD      5'd3
`define INSTR_STORE     5'd4
`define INSTR_HALT      5'd31
`endif

package stage_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = `STAGE_FETCH,
    ST_DECODE    = `STAGE_DECODE,
    ST_EXECUTE   = `STAGE_EXECUTE,
    ST_MEMORY    = `STAGE_MEMORY,
    ST_WRITEBACK = `STAGE_WRITEBACK,
    ST_HALTED    = `STAGE_HALTED
  } stage_e;

  localparam logic [4:0] INSTR_LOAD  = `INSTR_LOAD;
  localparam logic [4:0] INSTR_STORE = `INSTR_STORE;
  localparam logic [4:0] INSTR_HALT  = `INSTR_HALT;

  function automatic logic is_mem_instr(input logic [4:0] instr_type);
    return (instr_type == INSTR_LOAD) || (instr_type == INSTR_STORE);
  endfunction

endpackage

// File: rtl/stage_sequencer_pc_next.sv
// Next-PC selection: branch redirect or sequential step, always word aligned.
module pc_next_logic #(
  parameter logic [31:0] PC_INCREMENT = 32'd4
) (
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_next
);

  logic [31:0] pc_raw;

  // Sequential step wraps naturally at 2^32.
  assign pc_raw  = branch_taken ? branch_target : (pc + PC_INCREMENT);
  assign pc_next = pc_raw & ~32'd3;

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback control FSM.
// Optional STAGE_SEQUENCER_PERF_COUNTERS_EN adds cycle_count and retired_count outputs.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] PC_INCREMENT = 32'd4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       mem_read_data,
  input  logic              mem_ready,
  input  logic [4:0]        current_instr_type,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  output logic `STAGE_WIDTH stage,
  output logic [31:0]       PC_value,
  output logic [31:0]       instr_reg,
  output logic [31:0]       load_data,
  output logic              halted
`ifdef STAGE_SEQUENCER_PERF_COUNTERS_EN
  ,
  output logic [31:0]       cycle_count,
  output logic [31:0]       retired_count
`endif
);

  stage_e      state_q;
  stage_e      state_d;
  logic [31:0] pc_next;
  logic        is_store;
  logic        is_halt;

  assign is_store = (current_instr_type == INSTR_STORE);
  assign is_halt  = (current_instr_type == INSTR_HALT);
  assign stage    = state_q;

  pc_next_logic #(
    .PC_INCREMENT (PC_INCREMENT)
  ) u_pc_next (
    .pc            (PC_value),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_next       (pc_next)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:     if (mem_ready) state_d = ST_DECODE;
      ST_DECODE:    state_d = ST_EXECUTE;
      ST_EXECUTE:   state_d = is_mem_instr(current_instr_type) ? ST_MEMORY : ST_WRITEBACK;
      // Stores take exactly one cycle so the write strobe downstream pulses once.
      ST_MEMORY:    if (is_store || mem_ready) state_d = ST_WRITEBACK;
      ST_WRITEBACK: state_d = is_halt ? ST_HALTED : ST_FETCH;
      ST_HALTED:    state_d = ST_HALTED;
      default:      state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      PC_value  <= RESET_PC;
      instr_reg <= 32'd0;
      load_data <= 32'd0;
      halted    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FETCH && mem_ready)
        instr_reg <= mem_read_data;
      if (state_q == ST_MEMORY && !is_store && mem_ready)
        load_data <= mem_read_data;
      // A HALT keeps its own address in the PC.
      if (state_q == ST_WRITEBACK) begin
        if (is_halt) halted   <= 1'b1;
        else         PC_value <= pc_next;
      end
    end
  end

`ifdef STAGE_SEQUENCER_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count   <= 32'd0;
      retired_count <= 32'd0;
    end else begin
      if (!halted)
        cycle_count <= cycle_count + 32'd1;
      if (state_q == ST_WRITEBACK)
        retired_count <= retired_count + 32'd1;
    end
  end
`endif

endmodule
